// File: rtl/add_chain_pkg.sv
// Shared defaults and limits for the add-chain pipeline and its stage.
package add_chain_pkg;
    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_STAGES = 2;
    localparam int unsigned DEF_STEP   = 1;
    localparam int unsigned MAX_STAGES = 16;
endpackage

// File: rtl/add_chain_stage.sv
// One pipeline register stage: valid bit, data register and +STEP adder.
module add_chain_stage
    import add_chain_pkg::*;
#(
    parameter int unsigned      WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] STEP  = WIDTH'(DEF_STEP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    input  logic             i_down_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_ready;
    logic             w_load;

    assign w_ready = !r_valid || i_down_ready;
    assign w_load  = i_up_valid && w_ready && !flush;

    // When ready, the valid bit simply follows upstream: load sets it,
    // a hand-off with nothing arriving clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_ready) begin
                r_valid <= i_up_valid;
            end
            if (w_load) begin
                r_data <= i_up_data + STEP;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/add_chain_pipeline.sv
// Elastic pipeline adding STEP in each of STAGES register stages, with
// bubble collapse, flush and a registered occupancy counter.
module add_chain_pipeline
    import add_chain_pkg::*;
#(
    parameter int unsigned      WIDTH  = DEF_WIDTH,
    parameter int unsigned      STAGES = DEF_STAGES,
    parameter logic [WIDTH-1:0] STEP   = WIDTH'(DEF_STEP)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);
    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] w_valid;
    logic [WIDTH-1:0]  w_data    [STAGES];
    logic [STAGES-1:0] w_up_valid;
    logic [WIDTH-1:0]  w_up_data [STAGES];
    logic [STAGES:0]   w_ready;
    logic              w_in_hs;
    logic              w_out_hs;
    logic [OCC_W-1:0]  r_occupancy;

    assign w_ready[STAGES] = out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Closed form of ready_k = !valid_k || ready_(k+1): stage k is
            // ready unless it and every stage after it are full and stalled.
            assign w_ready[gi] = out_ready || !(&w_valid[STAGES-1:gi]);

            if (gi == 0) begin : g_first
                assign w_up_valid[gi] = in_valid;
                assign w_up_data[gi]  = in_data;
            end else begin : g_next
                assign w_up_valid[gi] = w_valid[gi-1];
                assign w_up_data[gi]  = w_data[gi-1];
            end

            add_chain_stage #(
                .WIDTH (WIDTH),
                .STEP  (STEP)
            ) u_stage (
                .clk          (clk),
                .rst          (rst),
                .flush        (flush),
                .i_up_valid   (w_up_valid[gi]),
                .i_up_data    (w_up_data[gi]),
                .i_down_ready (w_ready[gi+1]),
                .o_valid      (w_valid[gi]),
                .o_data       (w_data[gi])
            );
        end
    endgenerate

    assign in_ready  = w_ready[0] && !flush;
    assign out_valid = w_valid[STAGES-1];
    assign out_data  = w_data[STAGES-1];
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occupancy <= '0;
        end else if (flush) begin
            r_occupancy <= '0;
        end else if (w_in_hs && !w_out_hs) begin
            r_occupancy <= r_occupancy + OCC_W'(1);
        end else if (!w_in_hs && w_out_hs) begin
            r_occupancy <= r_occupancy - OCC_W'(1);
        end
    end

    assign occupancy = r_occupancy;
endmodule

// File: tb/tb_add_chain_pipeline.sv
// Scoreboard bench for add_chain_pipeline (defaults) plus a directed
// check of a STAGES=4, STEP=3 instance.
module tb_add_chain_pipeline;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;

    logic        rst4, in_valid4, in_ready4, out_valid4;
    logic        flush4, out_ready4;
    logic [31:0] in_data4, out_data4;
    logic [2:0]  occupancy4;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    add_chain_pipeline dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    add_chain_pipeline #(.WIDTH(32), .STAGES(4), .STEP(32'd3)) dut4 (
        .clk       (clk),
        .rst       (rst4),
        .flush     (flush4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .occupancy (occupancy4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected results on every output handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            chk("occupancy_vs_model", 32'(occupancy), 32'(exp_q.size()));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output actual=%0h required=none", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("out_data", out_data, mon_exp);
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(in_data + 32'd2);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        rst4 = 1'b1; flush4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
        #2;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_occupancy", 32'(occupancy), 0);
        cyc(2);
        rst = 1'b0; rst4 = 1'b0;

        // Single item, latency and occupancy 1,1,0
        in_valid = 1'b1; in_data = 32'h5; #1;
        chk("single_in_ready", 32'(in_ready), 1);
        cyc(); in_valid = 1'b0;
        chk("single_occ_a", 32'(occupancy), 1);
        chk("single_valid_a", 32'(out_valid), 0);
        cyc();
        chk("single_occ_b", 32'(occupancy), 1);
        chk("single_valid_b", 32'(out_valid), 1);
        chk("single_data", out_data, 32'h7);
        cyc();
        chk("single_occ_c", 32'(occupancy), 0);
        chk("single_valid_c", 32'(out_valid), 0);

        // Wrap-around
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        cyc(); in_valid = 1'b0;
        cyc();
        chk("wrap_valid", 32'(out_valid), 1);
        chk("wrap_data", out_data, 32'h1);
        cyc();

        // Back-to-back stream 0..3 -> 2..5
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'(i); #1;
            chk($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 1);
            cyc();
            if (i >= 1) begin
                chk($sformatf("stream_valid_%0d", i), 32'(out_valid), 1);
                chk($sformatf("stream_data_%0d", i), out_data, 32'(i + 1));
            end
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_valid_last", 32'(out_valid), 1);
        chk("stream_data_last", out_data, 32'h5);
        cyc();
        chk("stream_drained", 32'(out_valid), 0);

        // Backpressure: third push refused until out_ready rises
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'd10; #1;
        chk("bp_in_ready_0", 32'(in_ready), 1);
        cyc(); in_data = 32'd11; #1;
        chk("bp_in_ready_1", 32'(in_ready), 1);
        cyc(); in_data = 32'd12; #1;
        chk("bp_in_ready_full", 32'(in_ready), 0);
        chk("bp_occ_full", 32'(occupancy), 2);
        chk("bp_out_data", out_data, 32'd12);
        cyc();
        chk("bp_hold_data", out_data, 32'd12);
        chk("bp_hold_occ", 32'(occupancy), 2);
        chk("bp_hold_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1; #1;
        chk("bp_full_passthrough", 32'(in_ready), 1);
        cyc(); in_valid = 1'b0;
        cyc(3);
        chk("bp_occ_end", 32'(occupancy), 0);

        // Flush with two items in flight and in_valid high
        in_valid = 1'b1; in_data = 32'd20;
        cyc(); in_data = 32'd21;
        cyc(); in_data = 32'd50; flush = 1'b1; #1;
        chk("flush_in_ready", 32'(in_ready), 0);
        chk("flush_occ_before", 32'(occupancy), 2);
        chk("flush_out_valid", 32'(out_valid), 1);
        cyc(); flush = 1'b0; in_valid = 1'b0;
        chk("flush_occ_after", 32'(occupancy), 0);
        chk("flush_out_valid_after", 32'(out_valid), 0);
        cyc(3);
        chk("flush_no_ghost", 32'(out_valid), 0);

        // Reset mid-operation, acceptance in the first cycle afterwards
        in_valid = 1'b1; in_data = 32'd30;
        cyc(); in_data = 32'd31;
        cyc(); in_valid = 1'b0; rst = 1'b1; #1;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_data", out_data, 0);
        chk("rst_mid_occ", 32'(occupancy), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 1);
        cyc(); rst = 1'b0; in_valid = 1'b1; in_data = 32'd7; #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        cyc(); in_valid = 1'b0;
        cyc();
        chk("post_rst_data", out_data, 32'd9);
        cyc();

        // STAGES=4, STEP=3 instance
        in_valid4 = 1'b1; in_data4 = 32'd1;
        cyc(); in_data4 = 32'd2;
        cyc(); in_valid4 = 1'b0;
        cyc(); rst4 = 1'b1; #1;
        chk("s4_rst_valid", 32'(out_valid4), 0);
        chk("s4_rst_data", out_data4, 0);
        chk("s4_rst_occ", 32'(occupancy4), 0);
        cyc(); rst4 = 1'b0; in_valid4 = 1'b1; in_data4 = 32'd10;
        cyc(); in_valid4 = 1'b0;
        cyc(2);
        chk("s4_valid_early", 32'(out_valid4), 0);
        cyc();
        chk("s4_valid", 32'(out_valid4), 1);
        chk("s4_data", out_data4, 32'd22);
        chk("s4_occ", 32'(occupancy4), 1);
        cyc();
        chk("s4_valid_after", 32'(out_valid4), 0);

        cyc(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
